// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access size codes, data_mem op codes,
// LSU FSM states and the latched request record.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_WORD = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_BYTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SPLIT,
    ST_RESP
  } lsu_state_e;

  typedef struct packed {
    logic        we;
    size_e       size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Index of the last byte touched by an access (bytes - 1).
  function automatic logic [1:0] size_last(input size_e s);
    case (s)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] size_op(input size_e s);
    case (s)
      SZ_BYTE: return MEM_BYTE;
      SZ_HALF: return MEM_HALF;
      SZ_WORD: return MEM_WORD;
      default: return MEM_NONE;
    endcase
  endfunction

  function automatic logic is_aligned(input size_e s, input logic [1:0] a);
    case (s)
      SZ_HALF: return (a[0] == 1'b0);
      SZ_WORD: return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Request/response handshake plus the data_mem bus driven by the LSU.
interface mem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  write_mem;
  logic [2:0]  read_mem;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] out_mem;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, out_mem,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           write_mem, read_mem, address, write_data
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, out_mem,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           write_mem, read_mem, address, write_data
  );
endinterface

// File: rtl/lsu_extend.sv
// Sign/zero extension of an assembled load value by access size.
module lsu_extend
  import mem_pkg::*;
(
  input  logic [31:0] val_i,
  input  size_e       size_i,
  input  logic        sgn_i,
  output logic [31:0] val_o
);
  always_comb begin
    val_o = val_i;
    case (size_i)
      SZ_BYTE: val_o = {{24{sgn_i & val_i[7]}},  val_i[7:0]};
      SZ_HALF: val_o = {{16{sgn_i & val_i[15]}}, val_i[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: one request at a time, misaligned half/word accesses are
// broken into byte cycles and reassembled before the one-cycle response.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic       clk,
  input  logic       rst,
  mem_lsu_if.master  bus
);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  size_e       in_size;
  logic [32:0] in_end;
  logic        in_bad;
  logic [31:0] acc_merge, ext_in, ext_out;
  logic [7:0]  wbyte;

  assign in_size = size_e'(bus.req_size);
  // 33-bit sum so addresses near 2^32 cannot wrap back into range
  assign in_end  = {1'b0, bus.req_addr} + {31'b0, size_last(in_size)};
  assign in_bad  = (in_size == SZ_ILL) || (in_end >= 33'(MEM_BYTES));

  assign acc_merge = acc_q | ({24'b0, bus.out_mem[7:0]} << {idx_q, 3'b000});
  assign ext_in    = (state_q == ST_SPLIT) ? acc_merge : bus.out_mem;

  lsu_extend u_ext (
    .val_i  (ext_in),
    .size_i (req_q.size),
    .sgn_i  (req_q.sgn),
    .val_o  (ext_out)
  );

  always_comb begin
    wbyte = req_q.wdata[7:0];
    case (idx_q)
      2'd1:    wbyte = req_q.wdata[15:8];
      2'd2:    wbyte = req_q.wdata[23:16];
      2'd3:    wbyte = req_q.wdata[31:24];
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.write_mem = MEM_NONE;
    bus.read_mem  = 3'b000;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          req_d.we    = bus.req_we;
          req_d.size  = in_size;
          req_d.sgn   = bus.req_signed;
          req_d.addr  = bus.req_addr;
          req_d.wdata = bus.req_wdata;
          idx_d       = 2'd0;
          acc_d       = '0;
          if (in_bad) begin
            state_d = ST_RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (is_aligned(in_size, bus.req_addr[1:0])) begin
            state_d = ST_ACCESS;
          end else begin
            state_d = ST_SPLIT;
          end
        end
      end
      ST_ACCESS: begin
        if (req_q.we) bus.write_mem = size_op(req_q.size);
        else          bus.read_mem  = {req_q.sgn & (req_q.size != SZ_WORD), size_op(req_q.size)};
        rdata_d = req_q.we ? '0 : ext_out;
        err_d   = 1'b0;
        state_d = ST_RESP;
      end
      ST_SPLIT: begin
        if (req_q.we) bus.write_mem = MEM_BYTE;
        else          bus.read_mem  = {1'b0, MEM_BYTE};
        acc_d = acc_merge;
        idx_d = idx_q + 2'd1;
        if (idx_q == size_last(req_q.size)) begin
          rdata_d = req_q.we ? '0 : ext_out;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_rdata  = rdata_q;
  assign bus.rsp_err    = err_q;
  assign bus.address    = req_q.addr + {30'b0, idx_q};
  assign bus.write_data = (state_q == ST_SPLIT) ? {24'b0, wbyte} : req_q.wdata;

endmodule
